// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared types and sizing for the sequential shift-add multiplier
package seq_mult_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction

    localparam int DEF_CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/seq_mult_n_if.sv
// seq_mult_n_if: operand/control and result bus of the sequential multiplier
interface seq_mult_n_if
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             ClearA_LoadB;
    logic             Execute;
    logic             Signed_mode;
    logic [WIDTH-1:0] Din;
    logic [WIDTH-1:0] Aval;
    logic [WIDTH-1:0] Bval;
    logic             X;
    logic             Busy;
    logic             Done;

    modport master (
        output ClearA_LoadB, Execute, Signed_mode, Din,
        input  Aval, Bval, X, Busy, Done
    );

    modport slave (
        input  ClearA_LoadB, Execute, Signed_mode, Din,
        output Aval, Bval, X, Busy, Done
    );

endinterface

// File: rtl/mult_addsub.sv
// mult_addsub: (WIDTH+1)-bit adder/subtractor with sign- or zero-extended operands
module mult_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] s,
    input  logic             signed_mode,
    input  logic             add,
    input  logic             sub,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH:0] ea;
    logic [WIDTH:0] es;
    logic [WIDTH:0] op;

    assign ea  = {signed_mode & a[WIDTH-1], a};
    assign es  = {signed_mode & s[WIDTH-1], s};
    // Subtraction as one's complement plus carry-in keeps a single adder
    assign op  = add ? (sub ? ~es : es) : '0;
    assign sum = ea + op + {{WIDTH{1'b0}}, add & sub};

endmodule

// File: rtl/seq_mult_n.sv
// seq_mult_n: shift-add multiplier, one multiplier bit per clock, product in {A,B}
module seq_mult_n
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic         Clk,
    input  logic         Reset,
    seq_mult_n_if.slave  bus
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic [CW-1:0]    count;
    logic             x;
    logic             mode;
    logic             busy;
    logic             done;
    logic             last;
    logic [WIDTH:0]   sum;

    assign last = count == CW'(WIDTH - 1);

    // In two's-complement mode the final multiplier bit carries negative weight
    mult_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a          (a),
        .s          (s),
        .signed_mode(mode),
        .add        (b[0]),
        .sub        (mode & last),
        .sum        (sum)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            s     <= '0;
            count <= '0;
            x     <= 1'b0;
            mode  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Execute) begin
                        s     <= bus.Din;
                        mode  <= bus.Signed_mode;
                        a     <= '0;
                        x     <= 1'b0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else if (bus.ClearA_LoadB) begin
                        b <= bus.Din;
                        a <= '0;
                        x <= 1'b0;
                    end
                end
                RUN: begin
                    x     <= mode & sum[WIDTH];
                    a     <= sum[WIDTH:1];
                    b     <= {sum[0], b[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!bus.Execute) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Aval = a;
    assign bus.Bval = b;
    assign bus.X    = x;
    assign bus.Busy = busy;
    assign bus.Done = done;

endmodule

// File: tb/tb_seq_mult_n.sv
// tb_seq_mult_n: randomized and directed checks of seq_mult_n against an arithmetic model
module tb_seq_mult_n;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] mb8 = 8'h00;

    always #5 clk = ~clk;

    seq_mult_n_if #(.WIDTH(8))  i8();
    seq_mult_n_if #(.WIDTH(16)) i16();

    seq_mult_n #(.WIDTH(8))  dut8  (.Clk(clk), .Reset(rst_n), .bus(i8.slave));
    seq_mult_n #(.WIDTH(16)) dut16 (.Clk(clk), .Reset(rst_n), .bus(i16.slave));

    // Full-precision product of the operands as integers in the chosen mode, truncated to 2w bits
    function automatic logic [63:0] ref_prod(input int w, input logic sgn, input logic [31:0] s,
                                             input logic [31:0] b);
        longint sx, bx;
        logic [63:0] p, mask;
        logic [31:0] wm;
        wm = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        s &= wm;
        b &= wm;
        sx = sgn ? (longint'($signed(s << (32 - w))) >>> (32 - w)) : longint'({32'b0, s});
        bx = sgn ? (longint'($signed(b << (32 - w))) >>> (32 - w)) : longint'({32'b0, b});
        p = 64'(sx * bx);
        mask = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
        return p & mask;
    endfunction

    task automatic load8(input logic [7:0] bv);
        i8.ClearA_LoadB = 1'b1;
        i8.Din = bv;
        @(negedge clk);
        i8.ClearA_LoadB = 1'b0;
        mb8 = bv;
    endtask

    // Starts a multiply and scribbles on the ignored inputs until Done or the cycle budget runs out
    task automatic run8(input logic [7:0] sv, input logic sgn, output logic [15:0] prod,
                        output logic xo, output int lat, output int bcnt);
        i8.Execute = 1'b1;
        i8.Din = sv;
        i8.Signed_mode = sgn;
        lat = 0;
        bcnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (i8.Busy) bcnt++;
            i8.Din = 8'($urandom);
            i8.Signed_mode = 1'($urandom);
            i8.ClearA_LoadB = 1'($urandom);
        end while (!i8.Done && lat < 40);
        prod = {i8.Aval, i8.Bval};
        xo = i8.X;
        i8.ClearA_LoadB = 1'b0;
    endtask

    task automatic release8();
        i8.Execute = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({i8.Aval, i8.Bval, i8.X, i8.Busy, i8.Done} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset8: got %h expected 0", {i8.Aval, i8.Bval, i8.X, i8.Busy, i8.Done});
        end
        n_checks++;
        if ({i16.Aval, i16.Bval, i16.X, i16.Busy, i16.Done} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset16: got %h expected 0", {i16.Aval, i16.Bval, i16.X, i16.Busy, i16.Done});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        logic [7:0]  tb_b[5] = '{8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFF};
        logic [7:0]  tb_s[5] = '{8'hCA, 8'hCA, 8'h01, 8'hFF, 8'hFF};
        logic        tb_m[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [15:0] tb_p[5] = '{16'hC86C, 16'h006C, 16'hFFFF, 16'h0001, 16'hFE01};
        logic [15:0] prod;
        logic        xo;
        int          lat, bcnt;
        for (int i = 0; i < 5; i++) begin
            load8(tb_b[i]);
            run8(tb_s[i], tb_m[i], prod, xo, lat, bcnt);
            n_checks++;
            if ({prod, xo, 8'(lat), 8'(bcnt)} !== {tb_p[i], tb_m[i] & tb_p[i][15], 8'd9, 8'd8}) begin
                n_fail++;
                $display("FAIL vector%0d: prod=%h x=%b lat=%0d busy=%0d expected prod=%h x=%b lat=9 busy=8",
                         i, prod, xo, lat, bcnt, tb_p[i], tb_m[i] & tb_p[i][15]);
            end
            mb8 = prod[7:0];
            release8();
        end
    endtask

    task automatic test_chain();
        logic [15:0] prod;
        logic        xo;
        int          lat, bcnt, bad;
        load8(8'h02);
        run8(8'h03, 1'b0, prod, xo, lat, bcnt);
        n_checks++;
        if ({prod, xo, 8'(lat)} !== {16'h0006, 1'b0, 8'd9}) begin
            n_fail++;
            $display("FAIL chain1: prod=%h x=%b lat=%0d expected 0006 0 9", prod, xo, lat);
        end
        release8();
        run8(8'h04, 1'b0, prod, xo, lat, bcnt);
        n_checks++;
        if ({prod, xo, 8'(lat)} !== {16'h0018, 1'b0, 8'd9}) begin
            n_fail++;
            $display("FAIL chain2: prod=%h x=%b lat=%0d expected 0018 0 9", prod, xo, lat);
        end
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (i8.Busy || i8.Done) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL hold_no_rerun: %0d cycles with Busy/Done while Execute held, expected 0", bad);
        end
        n_checks++;
        if ({i8.Aval, i8.Bval} !== 16'h0018) begin
            n_fail++;
            $display("FAIL hold_product: got %h expected 0018", {i8.Aval, i8.Bval});
        end
        mb8 = 8'h18;
        release8();
    endtask

    task automatic test_random();
        logic [15:0] prod, expv;
        logic [7:0]  sv;
        logic        xo, sg;
        int          lat, bcnt;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(1) == 1) load8(8'($urandom));
            sv = 8'($urandom);
            sg = 1'($urandom);
            expv = 16'(ref_prod(8, sg, {24'b0, sv}, {24'b0, mb8}));
            run8(sv, sg, prod, xo, lat, bcnt);
            n_checks++;
            if ({prod, xo, 8'(lat), 8'(bcnt)} !== {expv, sg & expv[15], 8'd9, 8'd8}) begin
                n_fail++;
                $display("FAIL random%0d: s=%h b=%h sgn=%b prod=%h x=%b lat=%0d busy=%0d expected %h x=%b lat=9 busy=8",
                         i, sv, mb8, sg, prod, xo, lat, bcnt, expv, sg & expv[15]);
            end
            mb8 = expv[7:0];
            release8();
        end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] prod;
        logic        xo;
        int          lat, bcnt;
        load8(8'hB7);
        i8.Execute = 1'b1;
        i8.Din = 8'h5D;
        i8.Signed_mode = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({i8.Aval, i8.Bval, i8.X, i8.Busy, i8.Done} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got %h expected 0", {i8.Aval, i8.Bval, i8.X, i8.Busy, i8.Done});
        end
        i8.Execute = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({i8.Busy, i8.Done, i8.Bval} !== 10'd0) begin
            n_fail++;
            $display("FAIL after_reset_idle: busy=%b done=%b b=%h expected 0 0 00", i8.Busy, i8.Done, i8.Bval);
        end
        mb8 = 8'h00;
        run8(8'h77, 1'b0, prod, xo, lat, bcnt);
        n_checks++;
        if ({prod, xo, 8'(lat)} !== {16'h0000, 1'b0, 8'd9}) begin
            n_fail++;
            $display("FAIL post_reset_mult: prod=%h x=%b lat=%0d expected 0000 0 9", prod, xo, lat);
        end
        release8();
    endtask

    task automatic test_width16();
        logic [15:0] bv, sv;
        logic [31:0] expv, prod;
        logic        sg, xo;
        int          lat, bcnt;
        for (int k = 0; k < 4; k++) begin
            bv = (k == 0) ? 16'h7FFF : 16'($urandom);
            sv = (k == 0) ? 16'h8000 : 16'($urandom);
            sg = (k == 0) ? 1'b1 : 1'($urandom);
            expv = (k == 0) ? 32'hC000_8000 : 32'(ref_prod(16, sg, {16'b0, sv}, {16'b0, bv}));
            i16.ClearA_LoadB = 1'b1;
            i16.Din = bv;
            @(negedge clk);
            i16.ClearA_LoadB = 1'b0;
            i16.Execute = 1'b1;
            i16.Din = sv;
            i16.Signed_mode = sg;
            lat = 0;
            bcnt = 0;
            do begin
                @(negedge clk);
                lat++;
                if (i16.Busy) bcnt++;
                i16.Din = 16'($urandom);
            end while (!i16.Done && lat < 60);
            prod = {i16.Aval, i16.Bval};
            xo = i16.X;
            n_checks++;
            if ({prod, xo, 8'(lat), 8'(bcnt)} !== {expv, sg & expv[31], 8'd17, 8'd16}) begin
                n_fail++;
                $display("FAIL width16_%0d: s=%h b=%h sgn=%b prod=%h x=%b lat=%0d busy=%0d expected %h x=%b lat=17 busy=16",
                         k, sv, bv, sg, prod, xo, lat, bcnt, expv, sg & expv[31]);
            end
            i16.Execute = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        i8.ClearA_LoadB = 1'b0;
        i8.Execute = 1'b0;
        i8.Signed_mode = 1'b0;
        i8.Din = '0;
        i16.ClearA_LoadB = 1'b0;
        i16.Execute = 1'b0;
        i16.Signed_mode = 1'b0;
        i16.Din = '0;
        #2 rst_n = 1'b0;
        test_reset();
        test_vectors();
        test_chain();
        test_random();
        test_reset_mid_run();
        test_width16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mult_n.md
# seq_mult_n

Parametrised sequential shift-add multiplier: next-generation lab5 multiplier datapath with selectable width, signed/unsigned mode and a busy/done handshake. Sits between the board I/O wrapper (switches, synchronised buttons, hex drivers) and the A/B/X register outputs. Computes a 2·WIDTH-bit product in {A,B} at one multiplier bit per clock. Supports chained multiplication by starting again with the previous low product in B.

## Interface
- WIDTH, 8, operand width in bits; legal range 4..32.
- Clk  in  1  rising-edge clock.
- Reset  in  1  active-low, asynchronous assert; release is synchronous to Clk upstream.
- ClearA_LoadB  in  1  active-high level; load Din into B and clear A and X. Synchronised upstream.
- Execute  in  1  active-high level; start a multiply with S = Din. Synchronised upstream.
- Signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled at start.
- Din  in  WIDTH  operand input (B on load, S on start).
- Aval  out  WIDTH  A register, high half of the product.
- Bval  out  WIDTH  B register, low half of the product.
- X  out  1  extension bit.
- Busy  out  1  high while a multiply is running.
- Done  out  1  one-cycle pulse on the cycle after the last iteration.

## Operation
- States: IDLE, RUN, HOLD. Reset (Reset=0) forces IDLE and clears A, B, X, S, the counter, Busy and Done, whatever the current state.
- IDLE, Execute=1: S←Din, mode←Signed_mode, A←0, X←0, B unchanged, count←0; go to RUN. Execute has priority over ClearA_LoadB in the same cycle.
- IDLE, ClearA_LoadB=1 and Execute=0: B←Din, A←0, X←0; stay in IDLE.
- RUN, one iteration per cycle, combined add and shift:
  - If B[0]=1, sum = {ext(A)} + {ext(S)}. On the final iteration with mode=1, subtract instead.
  - Otherwise sum = {ext(A)}.
  - ext means sign-extend to WIDTH+1 bits in signed mode and zero-extend in unsigned mode.
  - Next {X,A,B} = {xin, sum, B[WIDTH-1:1]}, where sum is WIDTH+1 bits and xin = sum[WIDTH] in signed mode, 0 in unsigned mode. Equivalently: arithmetic shift in signed mode, carry-in shift in unsigned mode.
  - After iteration WIDTH-1, go to HOLD.
- HOLD: Done pulses on entry. Stay in HOLD while Execute=1; go to IDLE when Execute=0. One multiply per Execute press.
- ClearA_LoadB and Signed_mode changes are ignored in RUN and HOLD. Din is ignored in RUN.
- Result: {Aval,Bval} = S×B_initial, truncated to 2·WIDTH bits and interpreted in the selected mode. X equals Aval[MSB] in signed mode and 0 in unsigned mode at completion.
- Chaining: a new Execute in IDLE multiplies the new S by the current Bval.

## Timing
- Start latency: Busy rises in the cycle after Execute is sampled high in IDLE.
- Busy stays high for exactly WIDTH cycles.
- Done is high for the single cycle after the final iteration; the product is valid in that same cycle and holds until the next start, load or reset.
- Start to Done = WIDTH+1 clocks.
- All outputs are registered; no combinational path from any input to any output.
- Reset assertion mid-RUN: all outputs are 0 immediately (asynchronously). The operation is not resumed.

## Structure
- Package seq_mult_pkg holds:
  - the state enum (IDLE, RUN, HOLD);
  - the default WIDTH constant;
  - the counter width, $clog2(WIDTH).
- One sub-module, mult_addsub: (WIDTH+1)-bit adder/subtractor with mode-dependent extension and a sub control input.
- Control FSM, counter and registers are kept in seq_mult_n.

## Test plan
- WIDTH=8, unsigned, B=FE, S=CA → {A,B}=C86C, X=0. Done comes 9 clocks after start.
- WIDTH=8, signed, B=FE, S=CA → 006C, X=0.
- WIDTH=8, signed: 01×FF → FFFF with X=1; FF×FF → 0001. Unsigned: FF×FF → FE01.
- WIDTH=8, chaining: load B=02, execute S=03 → 0006; release Execute, execute S=04 with no load → 0018. Holding Execute high past Done produces no second run.
- WIDTH=16, signed, S=8000, B=7FFF → C0008000. Busy high for exactly 16 cycles.
- Reset mid-RUN (cycle 3, WIDTH=8) → A, B, X, Busy and Done are 0 immediately; state is IDLE. ClearA_LoadB pulsed during RUN leaves B unaffected.
